// File: rtl/control_sequencer.sv
// control_sequencer: two-phase (fetch/execute) sequencer that holds phase,
// instruction register, PC and C/Z flags, and addresses the microcode decode table.
// Ports:
//   in:  clk, reset_n (async, active-low), halt, instr_data, alu_carry, alu_zero,
//        ctrl_word {incPC,loadPC,loadA,loadFlags,alu[2:0],bus[5:0]}
//   out: decode_addr {IR[15:12],carry_q,zero_q,phase}, pc_addr, operand (IR[11:0]),
//        phase, carry_q, zero_q
// Option SEQ_SINGLE_STEP_EN: adds input step / output stepping; each step pulse
// runs one fetch+execute pair, then the sequencer idles at phase 0.
module control_sequencer #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               halt,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               alu_carry,
    input  logic               alu_zero,
    input  logic [12:0]        ctrl_word,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step,
    output logic               stepping,
`endif
    output logic [6:0]         decode_addr,
    output logic [PC_W-1:0]    pc_addr,
    output logic [11:0]        operand,
    output logic               phase,
    output logic               carry_q,
    output logic               zero_q
);

    localparam int INC_PC     = 12;
    localparam int LOAD_PC    = 11;
    localparam int LOAD_FLAGS = 9;

    logic               phase_q, phase_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               carry_d, zero_d;
    logic               adv;

`ifdef SEQ_SINGLE_STEP_EN
    // run_q is set by the step pulse that performs the fetch edge and
    // cleared by the execute edge, so a step arriving mid-pair is ignored.
    logic run_q, run_d;

    assign adv      = !halt && (run_q || (!phase_q && step));
    assign stepping = !run_q;
`else
    assign adv = !halt;
`endif

    always_comb begin
        phase_d = phase_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        carry_d = carry_q;
        zero_d  = zero_q;
`ifdef SEQ_SINGLE_STEP_EN
        run_d   = run_q;
`endif
        if (adv) begin
            phase_d = !phase_q;
            if (!phase_q) begin
                ir_d = instr_data;
            end
            // loadPC wins over incPC; the jump target is the IR held
            // from the previous fetch.
            if (ctrl_word[LOAD_PC]) begin
                pc_d = ir_q[PC_W-1:0];
            end else if (ctrl_word[INC_PC]) begin
                pc_d = pc_q + 1'b1;
            end
            if (phase_q && ctrl_word[LOAD_FLAGS]) begin
                carry_d = alu_carry;
                zero_d  = alu_zero;
            end
`ifdef SEQ_SINGLE_STEP_EN
            run_d = !phase_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
            ir_q    <= '0;
            pc_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
            run_q   <= 1'b0;
`endif
        end else begin
            phase_q <= phase_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
`ifdef SEQ_SINGLE_STEP_EN
            run_q   <= run_d;
`endif
        end
    end

    assign phase       = phase_q;
    assign pc_addr     = pc_q;
    assign operand     = ir_q[11:0];
    assign decode_addr = {ir_q[INSTR_W-1 -: 4], carry_q, zero_q, phase_q};

endmodule
